// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a FIFO; frames go out back-to-back.
// Optional overflow flag (ports ovf_clr/ovf) enabled by defining UART_TX_OVF_FLAG_EN.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic                          tx_done
`ifdef UART_TX_OVF_FLAG_EN
    ,
    input  logic                          ovf_clr,
    output logic                          ovf
`endif
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CBW = $clog2(STOP_BITS * DIV);
    localparam int BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state, next_state;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   sh;
    logic                   par_bit;
    logic [CBW-1:0]         cnt;
    logic [BW-1:0]          bidx;
    logic                   push, pop, tick;

    assign full  = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign empty = fifo_count == '0;
    assign push  = wr_en && !full;
    assign tick  = cnt == (state == STOP ? CBW'(STOP_BITS * DIV - 1) : CBW'(DIV - 1));

    // FIFO storage, written only on accepted pushes
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end

    // FSM state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;

    // baud counter restarts every state; popped word and its parity are latched on pop
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt     <= '0;
            bidx    <= '0;
            sh      <= '0;
            par_bit <= 1'b0;
        end else begin
            cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            if (pop) begin
                sh      <= mem[rd_ptr];
                par_bit <= ^mem[rd_ptr] ^ (PARITY == 1);
                bidx    <= '0;
            end else if (state == DATA && tick) begin
                sh   <= sh >> 1;
                bidx <= bidx + 1'b1;
            end
        end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty) next_state = START;
            START:   if (tick) next_state = DATA;
            DATA:    if (tick && bidx == BW'(DATA_BITS - 1)) next_state = PARITY != 0 ? PAR : STOP;
            PAR:     if (tick) next_state = STOP;
            STOP:    if (tick) next_state = empty ? IDLE : START;
            default: next_state = IDLE;
        endcase
    end

    // outputs decoded from state so reset forces the line idle immediately
    always_comb begin
        tx_busy   = state != IDLE;
        tx_done   = state == STOP && tick;
        pop       = !empty && (state == IDLE || tx_done);
        tx_serial = state == START ? 1'b0 : state == DATA ? sh[0] : state == PAR ? par_bit : 1'b1;
    end

`ifdef UART_TX_OVF_FLAG_EN
    // sticky overflow flag; a new overflow beats a simultaneous clear
    always_ff @(posedge clk or posedge rst)
        if (rst) ovf <= 1'b0;
        else if (wr_en && full) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo over four parameter sets.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam int DB [4] = '{8, 8, 8, 7};
    localparam int PR [4] = '{0, 2, 1, 0};
    localparam int SB [4] = '{1, 1, 1, 2};

    logic       we [4];
    logic [7:0] wd [4];
    logic       ser [4], busy [4], done [4], full [4], empty [4];
    logic [4:0] cnt [4];
`ifdef UART_TX_OVF_FLAG_EN
    logic       oc [4], ovf [4];
`endif
    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 4; g++) begin : d
        uart_tx_fifo #(
            .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(DB[g]), .PARITY(PR[g]),
            .STOP_BITS(SB[g]), .FIFO_DEPTH(16)
        ) u (
            .clk(clk), .rst(rst), .wr_en(we[g]), .wr_data(wd[g][DB[g]-1:0]),
            .full(full[g]), .empty(empty[g]), .fifo_count(cnt[g]),
            .tx_serial(ser[g]), .tx_busy(busy[g]), .tx_done(done[g])
`ifdef UART_TX_OVF_FLAG_EN
            , .ovf_clr(oc[g]), .ovf(ovf[g])
`endif
        );
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int i, input logic [7:0] v);
        we[i] = 1'b1;
        wd[i] = v;
        step;
        we[i] = 1'b0;
    endtask

    // bits: expected line level per bit period, first period in bit 0
    task automatic frame(input int i, input string tag, input logic [15:0] bits, input int nb);
        chk({tag, " idle_before_start"}, ser[i], 1);
        for (int k = 0; k < nb * 10; k++) begin
            step;
            chk({tag, " line"}, ser[i], bits[k / 10]);
            chk({tag, " done"}, done[i], k == nb * 10 - 1);
            chk({tag, " busy"}, busy[i], 1);
        end
        step;
        chk({tag, " busy_after"}, busy[i], 0);
        chk({tag, " done_after"}, done[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            we[i] = 1'b0;
            wd[i] = '0;
`ifdef UART_TX_OVF_FLAG_EN
            oc[i] = 1'b0;
`endif
        end
        // reset state, during and after reset
        repeat (5) begin
            step;
            chk("rst_ser", ser[0], 1);
            chk("rst_busy", busy[0], 0);
            chk("rst_empty", empty[0], 1);
            chk("rst_full", full[0], 0);
            chk("rst_cnt", cnt[0], 0);
        end
        rst = 1'b0;
        step;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_ser", ser[i], 1);
            chk("post_rst_busy", busy[i], 0);
            chk("post_rst_empty", empty[i], 1);
            chk("post_rst_cnt", cnt[i], 0);
            chk("post_rst_done", done[i], 0);
`ifdef UART_TX_OVF_FLAG_EN
            chk("post_rst_ovf", ovf[i], 0);
`endif
        end
        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        wr(0, 8'hA5);
        frame(0, "a5_8n1", 16'h034A, 10);
        // even parity 0x07 -> parity 1; odd -> parity 0
        wr(1, 8'h07);
        frame(1, "even_07", 16'h060E, 11);
        wr(2, 8'h07);
        frame(2, "odd_07", 16'h040E, 11);
        // 7 data bits, 2 stop bits, 0x55
        wr(3, 8'h55);
        frame(3, "55_7n2", 16'h03AA, 10);
        // 20 writes into a 16-deep FIFO: 17 accepted
        for (int k = 0; k < 20; k++) begin
            we[0] = 1'b1;
            wd[0] = 8'(k);
            step;
            if (k == 15) chk("ovr_not_full", full[0], 0);
            if (k == 16) chk("ovr_full", full[0], 1);
            if (k == 16) chk("ovr_cnt16", cnt[0], 16);
            if (k == 19) chk("ovr_cnt_held", cnt[0], 16);
`ifdef UART_TX_OVF_FLAG_EN
            if (k == 16) chk("ovf_clear_yet", ovf[0], 0);
            if (k == 17) chk("ovf_set", ovf[0], 1);
            if (k == 19) chk("ovf_sticky", ovf[0], 1);
`endif
        end
        we[0] = 1'b0;
        for (int s = 19; s < 1700; s++) begin
            int f, p;
            logic e;
`ifdef UART_TX_OVF_FLAG_EN
            oc[0] = (s == 19);
`endif
            step;
`ifdef UART_TX_OVF_FLAG_EN
            oc[0] = 1'b0;
            if (s == 19) chk("ovf_cleared", ovf[0], 0);
`endif
            f = s / 100;
            p = (s % 100) / 10;
            e = p == 0 ? 1'b0 : p == 9 ? 1'b1 : f[p-1];
            chk("burst_line", ser[0], e);
            chk("burst_done", done[0], (s % 100) == 99);
            chk("burst_busy", busy[0], 1);
        end
        step;
        chk("burst_idle_busy", busy[0], 0);
        chk("burst_idle_empty", empty[0], 1);
        chk("burst_idle_cnt", cnt[0], 0);
        // reset during data bit 4 of the first of three queued frames
        we[0] = 1'b1;
        wd[0] = 8'h00;
        repeat (3) step;
        we[0] = 1'b0;
        repeat (50) step;
        chk("abort_pre_ser", ser[0], 0);
        chk("abort_pre_busy", busy[0], 1);
        chk("abort_pre_cnt", cnt[0], 2);
        rst = 1'b1;
        #1;
        chk("abort_ser", ser[0], 1);
        chk("abort_busy", busy[0], 0);
        chk("abort_cnt", cnt[0], 0);
        chk("abort_empty", empty[0], 1);
        chk("abort_done", done[0], 0);
        repeat (3) begin
            step;
            chk("abort_hold_done", done[0], 0);
        end
        rst = 1'b0;
        repeat (250) begin
            step;
            chk("abort_after_ser", ser[0], 1);
            chk("abort_after_done", done[0], 0);
            chk("abort_after_busy", busy[0], 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
